pipe_reg: RTL and testbench

Parametrised, elastic successor to the fixed 16-bit datapath registers: a chain of DEPTH register stages, each WIDTH bits wide, with valid/ready handshaking at both ends, synchronous flush and an occupancy count. It sits between datapath units such as the multiplier and ALU result paths and the register file write-back. It absorbs downstream stalls without losing or duplicating words, and streams one word per cycle when unstalled.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_stage.sv | 40 ++++
 rtl/pipe_reg.sv | 105 ++++++++++
 tb/tb_pipe_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and occupancy-count width helper for the pipe_reg datapath
package pipe_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 1;

    // Count must represent 0..DEPTH+1 so the optional skid word always fits.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/data register with load, synchronous flush and async active-low reset
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_d,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Next state: flush wins, otherwise take the upstream word when this stage can advance.
    always_comb begin
        v_d = flush ? 1'b0 : load ? in_v : v_q;
        d_d = flush ? '0 : (load && in_v) ? in_d : d_q;
    end

    // State register, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: elastic DEPTH-stage valid/ready register chain with flush and occupancy count (optional skid: PIPE_REG_SKID_EN)
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH:0]   r;
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic             s0_v;
    logic [WIDTH-1:0] s0_d;
    logic             skid_v;

    // Ready ripples back from the output so bubbles collapse and a stalled chain fills completely.
    always_comb begin
        r[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) r[i] = !v[i] || r[i+1];
    end

`ifdef PIPE_REG_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;
    logic             rdy_q;
    logic             acc;

    assign in_ready = rdy_q && !flush;
    assign acc      = in_valid && in_ready;
    assign skid_v   = skid_v_q;

    // A parked word drains into stage 0 first; new input parks only when stage 0 cannot take it.
    always_comb begin
        skid_v_d = flush ? 1'b0 : skid_v_q ? !r[0] : (acc && !r[0]);
        skid_d_d = flush ? '0 : (acc && !r[0]) ? in_data : skid_d_q;
        s0_v     = skid_v_q || acc;
        s0_d     = skid_v_q ? skid_d_q : in_data;
    end

    // Skid register; in_ready is registered from the next skid state so it never depends on out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_v_q <= 1'b0;
            skid_d_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
            rdy_q    <= !skid_v_d;
        end
    end
`else
    assign skid_v   = 1'b0;
    assign in_ready = rst && r[0] && !flush;
    assign s0_v     = in_valid && in_ready;
    assign s0_d     = in_data;
`endif

    // Each stage is fed by the one before it; stage 0 by the input side.
    always_comb begin
        up_v[0] = s0_v;
        up_d[0] = s0_d;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .load  (r[g]),
            .in_v  (up_v[g]),
            .in_d  (up_d[g]),
            .v     (v[g]),
            .d     (d[g])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // Occupancy is the number of valid stages plus the skid word.
    always_comb begin
        count = CNT_W'(skid_v);
        for (int i = 0; i < DEPTH; i++) count = count + CNT_W'(v[i]);
    end

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: scoreboard bench for pipe_reg (DEPTH=3 main instance, DEPTH=1 side instance)
module tb_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic [2:0]  count;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [15:0] in_data1, out_data1;
    logic [1:0]  count1;
    logic [15:0] q[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    pipe_reg #(.WIDTH(16), .DEPTH(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .count(count)
    );

    pipe_reg #(.WIDTH(16), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready1), .count(count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every output handshake, record every accepted input word.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_pop: got word %h want none", out_data);
            end else begin
                chk("sb_data", {16'h0, out_data}, {16'h0, q.pop_front()});
            end
        end
        if (rst && in_valid && in_ready) q.push_back(in_data);
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_out_data", {16'h0, out_data}, 0);
        chk("rst_count", {29'h0, count}, 0);
        chk("rst_in_ready", {31'h0, in_ready}, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("rel_in_ready", {31'h0, in_ready}, 1);

        // stream 1..5 with out_ready=1
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(k);
            @(negedge clk);
            chk("stream_in_ready", {31'h0, in_ready}, 1);
            if (k == 3) chk("lat_not_yet", {31'h0, out_valid}, 0);
            if (k == 4) chk("lat_first", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h0001});
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("stream_drained", {29'h0, count}, 0);

        // backpressure: only three words fit
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hA0 + 16'(i);
            @(negedge clk);
            chk("bp_in_ready", {31'h0, in_ready}, (i < 3) ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_count", {29'h0, count}, 3);
        chk("bp_hold0", {16'h0, out_data}, 16'hA0);
        tick();
        @(negedge clk);
        chk("bp_hold1", {16'h0, out_data}, 16'hA0);

        // push and pop together while full
        tick();
        in_valid = 1'b1; in_data = 16'hA3; out_ready = 1'b1;
        @(negedge clk);
        chk("full_pp_in_ready", {31'h0, in_ready}, 1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("full_pp_count", {29'h0, count}, 3);
        chk("full_pp_head", {16'h0, out_data}, 16'hA1);
        tick();
        out_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("bp_drained", {29'h0, count}, 0);

        // flush with two held words and a word offered
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hB0 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_pre_count", {29'h0, count}, 2);
        tick();
        flush = 1'b1; in_valid = 1'b1; in_data = 16'hB2;
        @(negedge clk);
        chk("fl_in_ready", {31'h0, in_ready}, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_count", {29'h0, count}, 0);
        chk("fl_out_valid", {31'h0, out_valid}, 0);
        q.delete();
        repeat (3) tick();
        @(negedge clk);
        chk("fl_stays_empty", {29'h0, count}, 0);
        chk("fl_out_data", {16'h0, out_data}, 0);

        // async reset while full
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hC0 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar_full_count", {29'h0, count}, 3);
        chk("ar_full_out", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h00C0});
        #2 rst = 1'b0;
        #1;
        chk("ar_out_valid", {31'h0, out_valid}, 0);
        chk("ar_out_data", {16'h0, out_data}, 0);
        chk("ar_count", {29'h0, count}, 0);
        q.delete();
        tick();
        rst = 1'b1;
        tick();

        // DEPTH=1: single register with handshake
        in_valid1 = 1'b1; in_data1 = 16'h1234; out_ready1 = 1'b1;
        @(negedge clk);
        chk("d1_in_ready", {31'h0, in_ready1}, 1);
        tick();
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("d1_out", {15'h0, out_valid1, out_data1}, {15'h0, 1'b1, 16'h1234});
        chk("d1_count", {30'h0, count1}, 1);
        tick();
        @(negedge clk);
        chk("d1_popped", {31'h0, out_valid1}, 0);
        tick();
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 16'h0055;
        tick();
        in_data1 = 16'h0066;
        @(negedge clk);
        chk("d1_full_ready", {31'h0, in_ready1}, 0);
        chk("d1_full_count", {30'h0, count1}, 1);
        chk("d1_full_data", {16'h0, out_data1}, 16'h0055);
        tick();
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("d1_hold", {16'h0, out_data1}, 16'h0055);

        chk("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
